// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial add/sub controller: FSM encoding,
// slice width and a counter-width helper.
package add_seq_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n items, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead slice: byte sum plus group generate/propagate.
// Carry-out is formed by the caller as G | (P & cin).
module CLA_8bit (
    input  logic [7:0] dataA,
    input  logic [7:0] dataB,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       G,
    output logic       P
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic       gg;

    always_comb begin
        g    = dataA & dataB;
        p    = dataA ^ dataB;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 7; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = p ^ c;

        // Group generate: carry out of the slice assuming cin = 0.
        gg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gg = g[i] | (p[i] & gg);
        end
        G = gg;
        P = &p;
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add/subtract built by stepping one 8-bit CLA slice across the
// operands, LSB byte first, with a valid/ready handshake on both sides.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned KW     = cnt_w(NSLICE);
    localparam int unsigned MSB    = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;

    logic               accept_c;
    logic               last_c;
    logic [SLICE_W-1:0] a_byte_c;
    logic [SLICE_W-1:0] b_byte_c;
    logic [SLICE_W-1:0] sum_c;
    logic               g_c;
    logic               p_c;
    logic               cnext_c;
    logic [WIDTH-1:0]   result_nxt_c;

    assign accept_c = in_valid & in_ready;
    assign last_c   = (k == K_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c)  state_nxt = RUN;
            RUN:     if (last_c)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Current byte of the latched operands feeds the shared slice.
    always_comb begin
        a_byte_c = a_q[int'(k)*SLICE_W +: SLICE_W];
        b_byte_c = b_q[int'(k)*SLICE_W +: SLICE_W];
        result_nxt_c = result;
        result_nxt_c[int'(k)*SLICE_W +: SLICE_W] = sum_c;
    end

    CLA_8bit u_cla (
        .dataA (a_byte_c),
        .dataB (b_byte_c),
        .cin   (carry),
        .sum   (sum_c),
        .G     (g_c),
        .P     (p_c)
    );

    assign cnext_c = g_c | (p_c & carry);

    // Datapath and registered handshake/status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            k         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept_c) begin
                a_q   <= op_a;
                b_q   <= sub ? ~op_b : op_b;
                carry <= sub;
                k     <= '0;
            end else if (state == RUN) begin
                result <= result_nxt_c;
                carry  <= cnext_c;
                if (last_c) begin
                    k    <= '0;
                    cout <= cnext_c;
                    ovf  <= (a_q[MSB] == b_q[MSB]) & (result_nxt_c[MSB] != a_q[MSB]);
                    zero <= ~|result_nxt_c;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: hand-computed sums/differences, handshake
// timing, DONE hold behaviour and mid-operation reset.
module tb_add_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int LAT = 5;  // accept cycle counted as 1; out_valid seen in cycle 5

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation; hold = number of DONE cycles with out_ready low.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold, input logic [31:0] er,
                          input logic ec, input logic eo, input logic ez);
        int lat;
        int guard;
        @(negedge clock);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " lat"},    64'(lat),      64'(LAT));
        check({tag, " result"}, 64'(result),   64'(er));
        check({tag, " cout"},   64'(cout),     64'(ec));
        check({tag, " ovf"},    64'(ovf),      64'(eo));
        check({tag, " zero"},   64'(zero),     64'(ez));
        check({tag, " busy"},   64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            in_valid = 1'b1; op_a = $urandom; op_b = $urandom; sub = ~sub;
            @(posedge clock); #1;
            check({tag, " hold result"}, 64'(result),    64'(er));
            check({tag, " hold valid"},  64'(out_valid), 64'(1));
            check({tag, " hold ready"},  64'(in_ready),  64'(0));
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, " drained"}, 64'(out_valid), 64'(0));
        check({tag, " idle"},    64'(in_ready),  64'(1));
        repeat (2) @(posedge clock);
        #1;
        check({tag, " single"},  64'(out_valid), 64'(0));
    endtask

    initial begin
        int seen;
        #2;
        check("rst in_ready",  64'(in_ready),  64'(0));
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst result",    64'(result),    64'(0));
        check("rst flags",     64'({cout, ovf, zero}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post-rst in_ready", 64'(in_ready), 64'(1));

        run_op("ff+1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("5-7",     32'h0000_0005, 32'h0000_0007, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("7-5",     32'h0000_0007, 32'h0000_0005, 1'b1, 0, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op("negovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("hold",    32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clock);
        op_a = 32'h0102_0304; op_b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("abort out_valid", 64'(out_valid), 64'(0));
        check("abort in_ready",  64'(in_ready),  64'(0));
        check("abort result",    64'(result),    64'(0));
        check("abort flags",     64'({cout, ovf, zero}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("abort no completion", 64'(seen), 64'(0));
        run_op("post-abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
